// File: rtl/dma_responder.sv
// dma_responder: DMA engine at the responder end of the controller's DMA
// command interface. Each accepted command runs exactly one transfer.
//   op 0 INF : fetch the 64-bit layer descriptor (inf_conv)
//   op 1 FMI : input feature-map tile, memory -> buffer
//   op 2-4   : KEX/KPW/KDW kernel loads, memory -> buffer
//   op 5 FMO : output feature-map tile, buffer -> memory
//   op 6/7   : illegal, completes at once with dma_err
// Ports:
//   clk, rst (async, active-low)
//   s_dma, dma_op, dma_info1/2, dma_mem_info1/2 : command in
//   f_dma, dma_err, busy, inf_conv              : status out
//   ext_*                                       : external memory port
//   buf_*                                       : on-chip buffer port
module dma_responder #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int BUF_AW   = 12,
   parameter int INF_BASE = 32'h0,
   parameter int FMI_BASE = 32'h100,
   parameter int KEX_BASE = 32'h4000,
   parameter int KPW_BASE = 32'h6000,
   parameter int KDW_BASE = 32'h7000,
   parameter int FMO_BASE = 32'h8000,
   parameter int KEX_LEN  = 16,
   parameter int KPW_LEN  = 16,
   parameter int KDW_LEN  = 9,
   parameter int TI_ROWS  = 4,
   parameter int TI_COLS  = 4,
   parameter int TO_ROWS  = 2,
   parameter int TO_COLS  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_dma,
   input  logic [2:0]        dma_op,
   input  logic [31:0]       dma_info1,
   input  logic [31:0]       dma_info2,
   input  logic [31:0]       dma_mem_info1,
   input  logic [31:0]       dma_mem_info2,
   output logic              f_dma,
   output logic              dma_err,
   output logic              busy,
   output logic [63:0]       inf_conv,
   output logic              ext_req,
   output logic              ext_we,
   output logic [ADDR_W-1:0] ext_addr,
   output logic [DATA_W-1:0] ext_wdata,
   input  logic              ext_gnt,
   input  logic              ext_rvalid,
   input  logic [DATA_W-1:0] ext_rdata,
   output logic [2:0]        buf_sel,
   output logic [BUF_AW-1:0] buf_addr,
   output logic              buf_we,
   output logic [DATA_W-1:0] buf_wdata,
   input  logic [DATA_W-1:0] buf_rdata
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_FETCH = 3'd3,
      WR_ISSUE = 3'd4,
      DONE     = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] INF_B = ADDR_W'(INF_BASE);
   localparam logic [ADDR_W-1:0] FMI_B = ADDR_W'(FMI_BASE);
   localparam logic [ADDR_W-1:0] KEX_B = ADDR_W'(KEX_BASE);
   localparam logic [ADDR_W-1:0] KPW_B = ADDR_W'(KPW_BASE);
   localparam logic [ADDR_W-1:0] KDW_B = ADDR_W'(KDW_BASE);
   localparam logic [ADDR_W-1:0] FMO_B = ADDR_W'(FMO_BASE);
   localparam logic [15:0] KEX_LAST = 16'(KEX_LEN - 1);
   localparam logic [15:0] KPW_LAST = 16'(KPW_LEN - 1);
   localparam logic [15:0] KDW_LAST = 16'(KDW_LEN - 1);
   localparam logic [15:0] TI_R_LAST = 16'(TI_ROWS - 1);
   localparam logic [15:0] TI_C_LAST = 16'(TI_COLS - 1);
   localparam logic [15:0] TO_R_LAST = 16'(TO_ROWS - 1);
   localparam logic [15:0] TO_C_LAST = 16'(TO_COLS - 1);

   state_t              state_r, state_nx_s;
   logic [2:0]          op_r;
   logic [ADDR_W-1:0]   mi1_r, mi2_r, row_off_r;
   logic [31:0]         info1_r, info2_r;
   logic [15:0]         k_r, row_r, col_r;
   logic                err_r, wr_first_r;
   logic [DATA_W-1:0]   wdata_r;
   logic [63:0]         inf_conv_r;

   logic [7:0]          w8_s, wo8_s;
   logic [ADDR_W-1:0]   stride_s, tile_s, addr_s;
   logic                last_s, col_last_s, step_s;
   logic                ext_req_s, ext_we_s, buf_we_s;
   logic                dbg_unused_s;

   // Debug-only command fields are kept in registers but feed no logic.
   assign dbg_unused_s = ^{info1_r, info2_r};

   // Address generation and last-word detection for the latched command.
   always_comb begin
      w8_s       = inf_conv_r[7:0];
      wo8_s      = inf_conv_r[7:0] >> inf_conv_r[41];
      stride_s   = (op_r == 3'd5) ? ADDR_W'(wo8_s) : ADDR_W'(w8_s);
      tile_s     = mi2_r + mi1_r + row_off_r + ADDR_W'(col_r);
      col_last_s = (op_r == 3'd5) ? (col_r == TO_C_LAST) : (col_r == TI_C_LAST);
      case (op_r)
         3'd0: begin
            addr_s = INF_B + ADDR_W'(k_r);
            last_s = (k_r == 16'd1);
         end
         3'd1: begin
            addr_s = FMI_B + tile_s;
            last_s = (row_r == TI_R_LAST) && (col_r == TI_C_LAST);
         end
         3'd2: begin
            addr_s = KEX_B + mi1_r + ADDR_W'(k_r);
            last_s = (k_r == KEX_LAST);
         end
         3'd3: begin
            addr_s = KPW_B + mi1_r + ADDR_W'(k_r);
            last_s = (k_r == KPW_LAST);
         end
         3'd4: begin
            addr_s = KDW_B + mi1_r + ADDR_W'(k_r);
            last_s = (k_r == KDW_LAST);
         end
         3'd5: begin
            addr_s = FMO_B + tile_s;
            last_s = (row_r == TO_R_LAST) && (col_r == TO_C_LAST);
         end
         default: begin
            addr_s = {ADDR_W{1'b0}};
            last_s = 1'b1;
         end
      endcase
   end

   // Next-state logic and per-state strobes.
   always_comb begin
      state_nx_s = state_r;
      ext_req_s  = 1'b0;
      ext_we_s   = 1'b0;
      buf_we_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (s_dma) begin
               case (dma_op)
                  3'd0, 3'd1, 3'd2, 3'd3, 3'd4: state_nx_s = RD_ISSUE;
                  3'd5:                         state_nx_s = WR_FETCH;
                  default:                      state_nx_s = DONE;
               endcase
            end else begin
               state_nx_s = IDLE;
            end
         end
         RD_ISSUE: begin
            ext_req_s = 1'b1;
            if (ext_gnt) begin
               state_nx_s = RD_WAIT;
            end else begin
               state_nx_s = RD_ISSUE;
            end
         end
         RD_WAIT: begin
            if (ext_rvalid) begin
               buf_we_s   = (op_r != 3'd0);
               state_nx_s = last_s ? DONE : RD_ISSUE;
            end else begin
               state_nx_s = RD_WAIT;
            end
         end
         WR_FETCH: begin
            state_nx_s = WR_ISSUE;
         end
         WR_ISSUE: begin
            ext_req_s = 1'b1;
            ext_we_s  = 1'b1;
            if (ext_gnt) begin
               state_nx_s = last_s ? DONE : WR_FETCH;
            end else begin
               state_nx_s = WR_ISSUE;
            end
         end
         DONE: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   assign step_s = ((state_r == RD_WAIT) && ext_rvalid) || ((state_r == WR_ISSUE) && ext_gnt);

   // State register; reset drops any transfer in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Command latch and word/row/column counters; row offset grows by one stride per row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_r      <= 3'd0;
         mi1_r     <= {ADDR_W{1'b0}};
         mi2_r     <= {ADDR_W{1'b0}};
         info1_r   <= 32'd0;
         info2_r   <= 32'd0;
         err_r     <= 1'b0;
         k_r       <= 16'd0;
         row_r     <= 16'd0;
         col_r     <= 16'd0;
         row_off_r <= {ADDR_W{1'b0}};
      end else if ((state_r == IDLE) && s_dma) begin
         op_r      <= dma_op;
         mi1_r     <= ADDR_W'(dma_mem_info1);
         mi2_r     <= ADDR_W'(dma_mem_info2);
         info1_r   <= dma_info1;
         info2_r   <= dma_info2;
         err_r     <= (dma_op > 3'd5);
         k_r       <= 16'd0;
         row_r     <= 16'd0;
         col_r     <= 16'd0;
         row_off_r <= {ADDR_W{1'b0}};
      end else if (step_s) begin
         k_r <= k_r + 16'd1;
         if (col_last_s) begin
            col_r     <= 16'd0;
            row_r     <= row_r + 16'd1;
            row_off_r <= row_off_r + stride_s;
         end else begin
            col_r <= col_r + 16'd1;
         end
      end
   end

   // Descriptor register, written only by the two INF read returns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inf_conv_r <= 64'd0;
      end else if ((state_r == RD_WAIT) && ext_rvalid && (op_r == 3'd0)) begin
         if (k_r[0]) begin
            inf_conv_r[63:32] <= ext_rdata[31:0];
         end else begin
            inf_conv_r[31:0] <= ext_rdata[31:0];
         end
      end
   end

   // Write-data hold: buf_rdata is live on the first WR_ISSUE cycle, held afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_first_r <= 1'b0;
         wdata_r    <= {DATA_W{1'b0}};
      end else begin
         wr_first_r <= (state_nx_s == WR_ISSUE) && (state_r != WR_ISSUE);
         if (wr_first_r) begin
            wdata_r <= buf_rdata;
         end
      end
   end

   assign f_dma     = (state_r == DONE);
   assign dma_err   = (state_r == DONE) && err_r;
   assign busy      = (state_r != IDLE);
   assign inf_conv  = inf_conv_r;
   assign ext_req   = ext_req_s;
   assign ext_we    = ext_we_s;
   assign ext_addr  = ext_req_s ? addr_s : {ADDR_W{1'b0}};
   assign ext_wdata = ext_we_s ? (wr_first_r ? buf_rdata : wdata_r) : {DATA_W{1'b0}};
   assign buf_sel   = ((state_r != IDLE) && (op_r >= 3'd1) && (op_r <= 3'd5)) ? op_r : 3'd0;
   assign buf_addr  = (state_r != IDLE) ? BUF_AW'(k_r) : {BUF_AW{1'b0}};
   assign buf_we    = buf_we_s;
   assign buf_wdata = buf_we_s ? ext_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dma_responder.sv
// Table-driven bench for dma_responder with a zero-wait memory model
// and a 4-word FMO buffer model, plus hand sequences for stall and abort.
module tb_dma_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        s_dma = 1'b0;
   logic [2:0]  dma_op = 3'd0;
   logic [31:0] dma_info1 = 32'd0, dma_info2 = 32'd0;
   logic [31:0] dma_mem_info1 = 32'd0, dma_mem_info2 = 32'd0;
   logic        f_dma, dma_err, busy;
   logic [63:0] inf_conv;
   logic        ext_req, ext_we, ext_gnt;
   logic [31:0] ext_addr, ext_wdata;
   logic        ext_rvalid = 1'b0;
   logic [31:0] ext_rdata = 32'd0;
   logic [2:0]  buf_sel;
   logic [11:0] buf_addr;
   logic        buf_we;
   logic [31:0] buf_wdata;
   logic [31:0] buf_rdata = 32'd0;
   bit          stall = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] fmo_buf [4];
   logic [31:0] log_addr [$];
   logic        log_we   [$];
   logic [31:0] log_wd   [$];
   logic [11:0] bw_addr  [$];
   logic [2:0]  bw_sel   [$];
   logic [31:0] bw_data  [$];

   dma_responder #(
      .KEX_LEN(4), .KPW_LEN(3), .KDW_LEN(2),
      .TI_ROWS(2), .TI_COLS(3), .TO_ROWS(2), .TO_COLS(2)
   ) dut (
      .clk(clk), .rst(rst), .s_dma(s_dma), .dma_op(dma_op),
      .dma_info1(dma_info1), .dma_info2(dma_info2),
      .dma_mem_info1(dma_mem_info1), .dma_mem_info2(dma_mem_info2),
      .f_dma(f_dma), .dma_err(dma_err), .busy(busy), .inf_conv(inf_conv),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_we(buf_we),
      .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'd0)      return 32'h0010_0808;
      else if (a == 32'd1) return 32'h0000_0240;
      else                 return a ^ 32'h5A5A_0000;
   endfunction

   // Memory: grant in the request cycle, read data the cycle after.
   assign ext_gnt = ext_req && !stall;

   always @(posedge clk) begin
      ext_rvalid <= ext_req && ext_gnt && !ext_we;
      ext_rdata  <= mem_val(ext_addr);
      buf_rdata  <= fmo_buf[buf_addr[1:0]];
      if (ext_req && ext_gnt) begin
         log_addr.push_back(ext_addr);
         log_we.push_back(ext_we);
         log_wd.push_back(ext_wdata);
      end
      if (buf_we) begin
         bw_addr.push_back(buf_addr);
         bw_sel.push_back(buf_sel);
         bw_data.push_back(buf_wdata);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   typedef struct {
      logic [2:0]       op;
      logic [31:0]      mi1;
      logic [31:0]      mi2;
      int               n;
      logic [5:0][31:0] addr;
      logic             we;
      logic             err;
      int               done;
   } vec_t;

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] mi1, input logic [31:0] mi2,
                               input int n, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] a2, input logic [31:0] a3, input logic [31:0] a4,
                               input logic [31:0] a5, input logic we, input logic err, input int done);
      vec_t v;
      v.op = op; v.mi1 = mi1; v.mi2 = mi2; v.n = n;
      v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
      v.addr[3] = a3; v.addr[4] = a4; v.addr[5] = a5;
      v.we = we; v.err = err; v.done = done;
      return v;
   endfunction

   // Issue one command, then watch f_dma/busy. Optional gnt stall on word 1 with a
   // second s_dma thrown in while busy.
   task automatic run_cmd(input logic [2:0] op, input logic [31:0] mi1, input logic [31:0] mi2,
                          input bit stall_test, output int done_cyc, output int pulses,
                          output logic err_at, output logic busy_ok, output logic stable_ok);
      log_addr.delete(); log_we.delete(); log_wd.delete();
      bw_addr.delete(); bw_sel.delete(); bw_data.delete();
      @(negedge clk);
      s_dma = 1'b1; dma_op = op; dma_mem_info1 = mi1; dma_mem_info2 = mi2;
      dma_info1 = $urandom; dma_info2 = $urandom;
      @(negedge clk);
      s_dma = 1'b0;
      done_cyc = -1; pulses = 0; err_at = 1'b0; busy_ok = 1'b1; stable_ok = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         if (f_dma) begin
            pulses++;
            if (done_cyc < 0) begin
               done_cyc = c;
               err_at   = dma_err;
            end
         end
         if (done_cyc < 0 || c == done_cyc) begin
            if (!busy) busy_ok = 1'b0;
         end else if (busy) begin
            busy_ok = 1'b0;
         end
         if (stall_test) begin
            if (c == 2) stall = 1'b1;
            if (c >= 3 && c <= 6) begin
               if (!(ext_req === 1'b1 && ext_we === 1'b0 && ext_addr === 32'h6004)) stable_ok = 1'b0;
            end
            if (c == 4) begin
               s_dma = 1'b1; dma_op = 3'd2; dma_mem_info1 = 32'd8;
            end
            if (c == 5) s_dma = 1'b0;
            if (c == 6) stall = 1'b0;
         end
         if (done_cyc > 0 && c >= done_cyc + 3) break;
         @(negedge clk);
      end
   endtask

   vec_t vecs [8];

   initial begin
      int   done_cyc, pulses;
      logic err_at, busy_ok, stable_ok;
      int   exp_bw;

      fmo_buf[0] = 32'hA000_000A; fmo_buf[1] = 32'hB000_000B;
      fmo_buf[2] = 32'hC000_000C; fmo_buf[3] = 32'hD000_000D;

      vecs[0] = mk(3'd0, 32'd0, 32'd0, 2, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5);
      vecs[1] = mk(3'd2, 32'd8, 32'd0, 4, 32'h4008, 32'h4009, 32'h400A, 32'h400B, 32'h0, 32'h0, 1'b0, 1'b0, 9);
      vecs[2] = mk(3'd1, 32'd2, 32'd16, 6, 32'h112, 32'h113, 32'h114, 32'h11A, 32'h11B, 32'h11C, 1'b0, 1'b0, 13);
      vecs[3] = mk(3'd5, 32'd1, 32'd4, 4, 32'h8005, 32'h8006, 32'h8009, 32'h800A, 32'h0, 32'h0, 1'b1, 1'b0, 9);
      vecs[4] = mk(3'd4, 32'h10, 32'd0, 2, 32'h7010, 32'h7011, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5);
      // Address arithmetic wraps past 2^32.
      vecs[5] = mk(3'd2, 32'hFFFF_BFFE, 32'd0, 4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 9);
      // Illegal ops go straight to DONE: pulse in the cycle after the command.
      vecs[6] = mk(3'd6, 32'd0, 32'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1);
      vecs[7] = mk(3'd7, 32'd0, 32'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1);

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_status", {59'd0, f_dma, dma_err, busy, ext_req, ext_we}, 64'd0);
      chk("rst_buf", {51'd0, buf_we, buf_sel, buf_addr[8:0]}, 64'd0);
      chk("rst_inf", inf_conv, 64'd0);
      chk("rst_addr", {ext_addr, ext_wdata}, 64'd0);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_cmd(vecs[i].op, vecs[i].mi1, vecs[i].mi2, 1'b0, done_cyc, pulses, err_at, busy_ok, stable_ok);
         chk($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].done);
         chk($sformatf("v%0d_pulses", i), pulses, 1);
         chk($sformatf("v%0d_err", i), err_at, vecs[i].err);
         chk($sformatf("v%0d_busy", i), busy_ok, 1'b1);
         chk($sformatf("v%0d_n_ext", i), log_addr.size(), vecs[i].n);
         exp_bw = (vecs[i].op >= 3'd1 && vecs[i].op <= 3'd4) ? vecs[i].n : 0;
         chk($sformatf("v%0d_n_buf", i), bw_addr.size(), exp_bw);
         for (int j = 0; j < vecs[i].n; j++) begin
            if (j < log_addr.size()) begin
               chk($sformatf("v%0d_addr%0d", i, j), log_addr[j], vecs[i].addr[j]);
               chk($sformatf("v%0d_we%0d", i, j), log_we[j], vecs[i].we);
               if (vecs[i].we) chk($sformatf("v%0d_wdata%0d", i, j), log_wd[j], fmo_buf[j]);
            end
            if (j < bw_addr.size()) begin
               chk($sformatf("v%0d_bsel%0d", i, j), bw_sel[j], vecs[i].op);
               chk($sformatf("v%0d_baddr%0d", i, j), bw_addr[j], j);
               chk($sformatf("v%0d_bdata%0d", i, j), bw_data[j], mem_val(vecs[i].addr[j]));
            end
         end
         if (vecs[i].op == 3'd0) chk("inf_conv", inf_conv, 64'h0000_0240_0010_0808);
      end

      // KPW with gnt stalled three cycles on word 1 and a second s_dma while busy.
      run_cmd(3'd3, 32'd3, 32'd0, 1'b1, done_cyc, pulses, err_at, busy_ok, stable_ok);
      chk("stall_stable", stable_ok, 1'b1);
      chk("stall_done_cyc", done_cyc, 10);
      chk("stall_pulses", pulses, 1);
      chk("stall_n_ext", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
         chk("stall_addr0", log_addr[0], 32'h6003);
         chk("stall_addr1", log_addr[1], 32'h6004);
         chk("stall_addr2", log_addr[2], 32'h6005);
      end

      // Reset asserted in the middle of an FMO write.
      @(negedge clk);
      s_dma = 1'b1; dma_op = 3'd5; dma_mem_info1 = 32'd1; dma_mem_info2 = 32'd4;
      @(negedge clk);
      s_dma = 1'b0;
      @(negedge clk);
      chk("abort_pre_req", ext_req, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("abort_req", ext_req, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_inf", inf_conv, 64'd0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (f_dma) pulses++;
      end
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (f_dma) pulses++;
      end
      chk("abort_no_fdma", pulses, 0);

      run_cmd(3'd0, 32'd0, 32'd0, 1'b0, done_cyc, pulses, err_at, busy_ok, stable_ok);
      chk("post_rst_done_cyc", done_cyc, 5);
      chk("post_rst_pulses", pulses, 1);
      chk("post_rst_inf", inf_conv, 64'h0000_0240_0010_0808);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
